ddr3_app_responder: RTL

Synthesizable stand-in for the DDR3 controller user port: the responder end of the app_* command/write-data/read-data interface driven by our DDR3 traffic/test initiators. It models calibration, command and write-data back-pressure, a small backing memory and fixed-latency in-order read return. This lets initiators be simulated and board-tested without the memory IP. It sits where the DDR3 IP user interface would, with identical signal names and polarities.

---
 rtl/ddr3_app_responder.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/ddr3_app_responder.sv
// Stand-in for the DDR3 controller user port: calibration delay, queued commands and
// write data, a small byte-masked backing memory and fixed-latency in-order read return.

module ddr3_app_fifo #(
  parameter int W  = 8,
  parameter int AW = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  logic [W-1:0] mem [2**AW];
  logic [AW:0]  wptr, rptr;

  // Extra pointer bit separates full from empty when the low bits match.
  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign dout  = mem[rptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push && !full) wptr <= wptr + (AW+1)'(1);
      if (pop && !empty) rptr <= rptr + (AW+1)'(1);
    end

  always_ff @(posedge clk)
    if (push && !full) mem[wptr[AW-1:0]] <= din;
endmodule

module ddr3_app_responder #(
  parameter int ADDR_WIDTH     = 28,
  parameter int APP_DATA_WIDTH = 256,
  parameter int APP_MASK_WIDTH = 32,
  parameter int MEM_AW         = 6,
  parameter int RD_LATENCY     = 8,
  parameter int FIFO_AW        = 2,
  parameter int CALIB_CYCLES   = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      app_en,
  input  logic [2:0]                app_cmd,
  input  logic [ADDR_WIDTH-1:0]     app_addr,
  input  logic [APP_DATA_WIDTH-1:0] app_wdf_data,
  input  logic                      app_wdf_wren,
  input  logic                      app_wdf_end,
  input  logic [APP_MASK_WIDTH-1:0] app_wdf_mask,
  output logic                      app_rdy,
  output logic                      app_wdf_rdy,
  output logic [APP_DATA_WIDTH-1:0] app_rd_data,
  output logic                      app_rd_data_valid,
  output logic                      app_rd_data_end,
  output logic                      init_calib_complete,
  output logic                      cmd_error,
  output logic [31:0]               wr_count,
  output logic [31:0]               rd_count
);
  localparam int CNT_W = (CALIB_CYCLES > 0) ? $clog2(CALIB_CYCLES + 1) : 1;
  localparam int CW    = 3 + ADDR_WIDTH;
  localparam int DW    = APP_DATA_WIDTH + APP_MASK_WIDTH;

  typedef enum logic {CALIB, READY} cal_state_t;
  cal_state_t state, state_nxt;
  logic [CNT_W-1:0] cal_cnt;

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state   <= CALIB;
      cal_cnt <= CNT_W'(CALIB_CYCLES);
    end else begin
      state <= state_nxt;
      if (state == CALIB && cal_cnt != '0) cal_cnt <= cal_cnt - CNT_W'(1);
    end

  always_comb begin
    state_nxt = state;
    case (state)
      CALIB:   if (cal_cnt == '0) state_nxt = READY;
      READY:   state_nxt = READY;
      default: state_nxt = CALIB;
    endcase
  end

  assign init_calib_complete = (state == READY);

  logic                      cmd_full, cmd_empty, wdf_full, wdf_empty;
  logic                      cmd_pop, exec_wr, exec_rd, exec_ill;
  logic [CW-1:0]             cmd_head;
  logic [DW-1:0]             wdf_head;
  logic [2:0]                head_cmd;
  logic [ADDR_WIDTH-1:0]     head_addr;
  logic [APP_DATA_WIDTH-1:0] wdf_data_h;
  logic [APP_MASK_WIDTH-1:0] wdf_mask_h;
  logic [MEM_AW-1:0]         idx;

  // Ready is a function of registered FIFO state only; no pass-through on a full FIFO.
  assign app_rdy     = init_calib_complete && !cmd_full;
  assign app_wdf_rdy = init_calib_complete && !wdf_full;

  ddr3_app_fifo #(.W(CW), .AW(FIFO_AW)) u_cmd_fifo (
    .clk(clk), .rst(rst), .push(app_en && app_rdy), .din({app_cmd, app_addr}),
    .pop(cmd_pop), .dout(cmd_head), .full(cmd_full), .empty(cmd_empty));

  ddr3_app_fifo #(.W(DW), .AW(FIFO_AW)) u_wdf_fifo (
    .clk(clk), .rst(rst), .push(app_wdf_wren && app_wdf_rdy), .din({app_wdf_data, app_wdf_mask}),
    .pop(exec_wr), .dout(wdf_head), .full(wdf_full), .empty(wdf_empty));

  assign {head_cmd, head_addr}   = cmd_head;
  assign {wdf_data_h, wdf_mask_h} = wdf_head;
  assign idx = head_addr[MEM_AW+2:3];

  // A write head waits for its data; reads and illegal commands never wait.
  assign exec_wr  = !cmd_empty && (head_cmd == 3'b000) && !wdf_empty;
  assign exec_rd  = !cmd_empty && (head_cmd == 3'b001);
  assign exec_ill = !cmd_empty && (head_cmd[2:1] != 2'b00);
  assign cmd_pop  = exec_wr || exec_rd || exec_ill;

  logic [APP_DATA_WIDTH-1:0] mem [2**MEM_AW];

  always_ff @(posedge clk)
    if (exec_wr)
      for (int b = 0; b < APP_MASK_WIDTH; b++)
        if (!wdf_mask_h[b]) mem[idx][8*b +: 8] <= wdf_data_h[8*b +: 8];

  logic [RD_LATENCY:1]       vld_pipe;
  logic [APP_DATA_WIDTH-1:0] dat_pipe [1:RD_LATENCY];

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      vld_pipe <= '0;
      for (int s = 1; s <= RD_LATENCY; s++) dat_pipe[s] <= '0;
    end else begin
      vld_pipe    <= {vld_pipe[RD_LATENCY-1:1], exec_rd};
      dat_pipe[1] <= exec_rd ? mem[idx] : '0;
      for (int s = 2; s <= RD_LATENCY; s++) dat_pipe[s] <= dat_pipe[s-1];
    end

  assign app_rd_data       = dat_pipe[RD_LATENCY];
  assign app_rd_data_valid = vld_pipe[RD_LATENCY];
  assign app_rd_data_end   = vld_pipe[RD_LATENCY];

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_count  <= '0;
      rd_count  <= '0;
      cmd_error <= 1'b0;
    end else begin
      if (exec_wr)  wr_count  <= wr_count + 32'd1;
      if (exec_rd)  rd_count  <= rd_count + 32'd1;
      if (exec_ill) cmd_error <= 1'b1;
    end

  logic unused;
  assign unused = ^{app_wdf_end, head_addr[ADDR_WIDTH-1:MEM_AW+3], head_addr[2:0]};
endmodule
